// File: rtl/rate_detector_pkg.sv
// Shared constants for the rate detector: speed codes, nominal pulse periods,
// lock depth and the lock FSM state encoding.
package rate_detector_pkg;

   // Interval counter / period width
   localparam int unsigned CW             = 11;

   // Nominal cycles between enable pulses (shared with the rate divider)
   localparam int unsigned PERIOD_FULL    = 1;
   localparam int unsigned PERIOD_1HZ     = 500;
   localparam int unsigned PERIOD_HALF    = 1000;
   localparam int unsigned PERIOD_QUARTER = 2000;

   // Accepted deviation around each nominal period, in cycles
   localparam int unsigned TOL            = 2;

   // Consecutive matching periods required before the code is trusted
   localparam int unsigned LOCK_COUNT     = 2;
   localparam int unsigned MCW            = $clog2(LOCK_COUNT + 1);

   // Counter saturation value and the value just before it
   localparam logic [CW-1:0] CNT_MAX      = CW'((2 ** CW) - 1);
   localparam logic [CW-1:0] CNT_PRESAT   = CW'((2 ** CW) - 2);

   typedef enum logic [1:0] {
      SPD_FULL    = 2'b00,
      SPD_1HZ     = 2'b01,
      SPD_HALF    = 2'b10,
      SPD_QUARTER = 2'b11
   } speed_e;

   typedef enum logic [1:0] {
      S_SEARCH = 2'b00,
      S_TRACK  = 2'b01,
      S_LOCKED = 2'b10
   } state_e;

   // True when period p lies within nom +/- TOL (written to avoid unsigned underflow)
   function automatic logic in_range(input int unsigned p, input int unsigned nom);
      return ((p + TOL) >= nom) && (p <= (nom + TOL));
   endfunction

endpackage

// File: rtl/rate_period_classifier.sv
// Combinational decode of a measured pulse period into a speed code.
// Ports:
//   period_i  - measured period in cycles
//   code_c_o  - decoded speed code (SPD_FULL when unmatched)
//   match_c_o - high when period_i falls inside one nominal window
module rate_period_classifier
   import rate_detector_pkg::*;
(
   input  logic [CW-1:0] period_i,
   output speed_e        code_c_o,
   output logic          match_c_o
);

   // Windows must be disjoint and fit in the counter, otherwise decode is ambiguous
   if (((PERIOD_FULL + 2 * TOL) >= PERIOD_1HZ)     ||
       ((PERIOD_1HZ  + 2 * TOL) >= PERIOD_HALF)    ||
       ((PERIOD_HALF + 2 * TOL) >= PERIOD_QUARTER) ||
       ((PERIOD_QUARTER + TOL)  >  ((2 ** CW) - 1))) begin : g_range_error
      $error("rate_period_classifier: nominal period windows overlap or exceed counter range");
   end

   logic [31:0] p_ext;

   always_comb begin
      p_ext     = 32'(period_i);
      code_c_o  = SPD_FULL;
      match_c_o = 1'b0;
      if (in_range(p_ext, PERIOD_FULL)) begin
         code_c_o  = SPD_FULL;
         match_c_o = 1'b1;
      end else if (in_range(p_ext, PERIOD_1HZ)) begin
         code_c_o  = SPD_1HZ;
         match_c_o = 1'b1;
      end else if (in_range(p_ext, PERIOD_HALF)) begin
         code_c_o  = SPD_HALF;
         match_c_o = 1'b1;
      end else if (in_range(p_ext, PERIOD_QUARTER)) begin
         code_c_o  = SPD_QUARTER;
         match_c_o = 1'b1;
      end
   end

endmodule

// File: rtl/rate_detector.sv
// Measures the spacing of a one-cycle enable pulse train, decodes it back into
// the 2-bit speed code and only reports the code once consecutive periods agree.
// Ports:
//   ClockIn     - system clock, posedge
//   Reset       - synchronous active-high reset
//   PulseIn     - enable pulse train, each high cycle is one pulse
//   SpeedOut    - last locked speed code
//   Locked      - high while the pulse train matches SpeedOut
//   PeriodOut   - most recently measured period in cycles
//   PeriodValid - one-cycle strobe when PeriodOut updates
//   Timeout     - high after no pulse for 2^CW-1 cycles
module rate_detector
   import rate_detector_pkg::*;
(
   input  logic          ClockIn,
   input  logic          Reset,
   input  logic          PulseIn,
   output logic [1:0]    SpeedOut,
   output logic          Locked,
   output logic [CW-1:0] PeriodOut,
   output logic          PeriodValid,
   output logic          Timeout
);

   state_e           state_q,     state_d;
   logic [CW-1:0]    int_cnt_q,   int_cnt_d;
   logic [MCW-1:0]   match_cnt_q, match_cnt_d;
   speed_e           cand_q,      cand_d;
   speed_e           speed_q,     speed_d;
   logic             locked_q,    locked_d;
   logic [CW-1:0]    period_q,    period_d;
   logic             pvalid_q,    pvalid_d;
   logic             timeout_q,   timeout_d;

   logic [CW-1:0]    period_c;
   logic [MCW-1:0]   match_inc_c;
   speed_e           code_c;
   logic             match_c;

   // Period ending on this pulse; the pulse cycle itself counts as one
   assign period_c    = int_cnt_q + CW'(1);
   assign match_inc_c = match_cnt_q + MCW'(1);

   rate_period_classifier u_classifier (
      .period_i  (period_c),
      .code_c_o  (code_c),
      .match_c_o (match_c)
   );

   // State and output registers
   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         state_q     <= S_SEARCH;
         int_cnt_q   <= '0;
         match_cnt_q <= '0;
         cand_q      <= SPD_FULL;
         speed_q     <= SPD_FULL;
         locked_q    <= 1'b0;
         period_q    <= '0;
         pvalid_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         int_cnt_q   <= int_cnt_d;
         match_cnt_q <= match_cnt_d;
         cand_q      <= cand_d;
         speed_q     <= speed_d;
         locked_q    <= locked_d;
         period_q    <= period_d;
         pvalid_q    <= pvalid_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state: interval counter, lock tracking and timeout
   always_comb begin
      state_d     = state_q;
      int_cnt_d   = int_cnt_q;
      match_cnt_d = match_cnt_q;
      cand_d      = cand_q;
      speed_d     = speed_q;
      locked_d    = locked_q;
      period_d    = period_q;
      pvalid_d    = 1'b0;
      timeout_d   = timeout_q;

      if (PulseIn) begin
         int_cnt_d = '0;
         timeout_d = 1'b0;
         unique case (state_q)
            // First pulse only establishes the reference edge
            S_SEARCH: begin
               state_d     = S_TRACK;
               match_cnt_d = '0;
            end
            S_TRACK: begin
               pvalid_d = 1'b1;
               period_d = period_c;
               if (!match_c) begin
                  match_cnt_d = '0;
               end else if ((match_cnt_q == '0) || (code_c == cand_q)) begin
                  cand_d      = code_c;
                  match_cnt_d = match_inc_c;
                  if (match_inc_c == MCW'(LOCK_COUNT)) begin
                     state_d  = S_LOCKED;
                     speed_d  = code_c;
                     locked_d = 1'b1;
                  end
               end else begin
                  cand_d      = code_c;
                  match_cnt_d = MCW'(1);
               end
            end
            S_LOCKED: begin
               pvalid_d = 1'b1;
               period_d = period_c;
               // Any deviation drops lock; SpeedOut keeps the old code until relock
               if (!(match_c && (code_c == speed_q))) begin
                  locked_d = 1'b0;
                  state_d  = S_TRACK;
                  if (match_c) begin
                     cand_d      = code_c;
                     match_cnt_d = MCW'(1);
                  end else begin
                     match_cnt_d = '0;
                  end
               end
            end
            default: state_d = S_SEARCH;
         endcase
      end else begin
         if (int_cnt_q != CNT_MAX) begin
            int_cnt_d = int_cnt_q + CW'(1);
         end
         // Counter is about to saturate: the reference edge is lost
         if (int_cnt_q == CNT_PRESAT) begin
            timeout_d = 1'b1;
            if (state_q != S_SEARCH) begin
               state_d     = S_SEARCH;
               locked_d    = 1'b0;
               match_cnt_d = '0;
            end
         end
      end
   end

   assign SpeedOut    = speed_q;
   assign Locked      = locked_q;
   assign PeriodOut   = period_q;
   assign PeriodValid = pvalid_q;
   assign Timeout     = timeout_q;

endmodule

// File: tb/tb_rate_detector.sv
// Self-checking bench for rate_detector: directed scenarios plus a randomized
// pulse-gap run, all compared against a pulse-history reference model.
module tb_rate_detector;

   localparam int NOM [4] = '{1, 500, 1000, 2000};
   localparam int TOLC    = 2;
   localparam int LOCK_N  = 2;
   localparam int MAXC    = 2047;

   logic        ClockIn;
   logic        Reset;
   logic        PulseIn;
   logic [1:0]  SpeedOut;
   logic        Locked;
   logic [10:0] PeriodOut;
   logic        PeriodValid;
   logic        Timeout;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int          gap      = 0;
   bit          have_ref = 0;
   int          hist[$];
   logic        m_locked  = 1'b0;
   logic [1:0]  m_speed   = 2'b00;
   logic [10:0] m_period  = '0;
   logic        m_pv      = 1'b0;
   logic        m_timeout = 1'b0;

   logic [15:0] dut_bus;
   logic [15:0] mdl_bus;
   assign dut_bus = {SpeedOut, Locked, PeriodOut, PeriodValid, Timeout};
   assign mdl_bus = {m_speed, m_locked, m_period, m_pv, m_timeout};

   rate_detector dut (
      .ClockIn     (ClockIn),
      .Reset       (Reset),
      .PulseIn     (PulseIn),
      .SpeedOut    (SpeedOut),
      .Locked      (Locked),
      .PeriodOut   (PeriodOut),
      .PeriodValid (PeriodValid),
      .Timeout     (Timeout)
   );

   initial ClockIn = 1'b0;
   always #5 ClockIn = ~ClockIn;

   // Code whose nominal window contains per, or -1
   function automatic int classify(input int per);
      for (int i = 0; i < 4; i++) begin
         if ((per >= NOM[i] - TOLC) && (per <= NOM[i] + TOLC)) return i;
      end
      return -1;
   endfunction

   // Expected outputs after the coming clock edge, from pulse history
   task automatic model_step(input logic p);
      int  per;
      int  c;
      bit  lock_ok;
      if (Reset) begin
         gap = 0; have_ref = 0; hist.delete();
         m_locked = 0; m_speed = 0; m_period = 0; m_pv = 0; m_timeout = 0;
         return;
      end
      m_pv = 0;
      if (p) begin
         m_timeout = 0;
         if (have_ref) begin
            per      = gap + 1;
            m_pv     = 1;
            m_period = 11'(per);
            c        = classify(per);
            hist.push_back(c);
            if (m_locked) begin
               if (c != int'(m_speed)) m_locked = 0;
            end else if ((c >= 0) && (hist.size() >= LOCK_N)) begin
               lock_ok = 1;
               for (int k = 1; k <= LOCK_N; k++)
                  if (hist[hist.size() - k] != c) lock_ok = 0;
               if (lock_ok) begin
                  m_locked = 1;
                  m_speed  = 2'(c);
               end
            end
         end else begin
            have_ref = 1;
            hist.delete();
         end
         gap = 0;
      end else if (gap < MAXC) begin
         gap++;
         if (gap == MAXC) begin
            m_timeout = 1;
            have_ref  = 0;
            m_locked  = 0;
         end
      end
   endtask

   // Apply one cycle of PulseIn (from a negedge to the next negedge)
   task automatic drive(input logic p);
      PulseIn = p;
      model_step(p);
      @(negedge ClockIn);
   endtask

   // n-1 idle cycles then a pulse, giving a measured period of n
   task automatic pulse_gap(input int n);
      repeat (n - 1) drive(1'b0);
      drive(1'b1);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      drive(1'b1);
      drive(1'b0);
      n_tests++;
      if (dut_bus !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_values: got %h expected %h", dut_bus, 16'h0000);
      end
      n_tests++;
      if (dut_bus !== mdl_bus) begin
         n_fail++;
         $display("FAIL reset_model: got %h expected %h", dut_bus, mdl_bus);
      end
   endtask

   task automatic test_back_to_back();
      Reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1);
         n_tests++;
         if (dut_bus !== mdl_bus) begin
            n_fail++;
            $display("FAIL b2b_bus%0d: got %h expected %h", i, dut_bus, mdl_bus);
         end
         n_tests++;
         if (i == 0) begin
            if (PeriodValid !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_first_pv: got %b expected 0", PeriodValid);
            end
         end else if ({PeriodValid, PeriodOut} !== {1'b1, 11'd1}) begin
            n_fail++;
            $display("FAIL b2b_period%0d: got %b/%0d expected 1/1", i, PeriodValid, PeriodOut);
         end
         if (i == 2) begin
            n_tests++;
            if ({Locked, SpeedOut} !== 3'b100) begin
               n_fail++;
               $display("FAIL b2b_lock: got %b expected 100", {Locked, SpeedOut});
            end
         end
      end
   endtask

   task automatic test_1hz_lock();
      Reset = 1'b1;
      drive(1'b0);
      Reset = 1'b0;
      repeat (3) drive(1'b0);
      drive(1'b1);
      n_tests++;
      if ({PeriodValid, dut_bus} !== {1'b0, mdl_bus}) begin
         n_fail++;
         $display("FAIL hz1_first: got pv=%b %h expected pv=0 %h", PeriodValid, dut_bus, mdl_bus);
      end
      for (int k = 1; k <= 3; k++) begin
         pulse_gap(500);
         n_tests++;
         if (dut_bus !== mdl_bus) begin
            n_fail++;
            $display("FAIL hz1_bus%0d: got %h expected %h", k, dut_bus, mdl_bus);
         end
         n_tests++;
         if ({PeriodValid, PeriodOut, Locked, SpeedOut} !==
             {1'b1, 11'd500, (k >= 2), (k >= 2) ? 2'b01 : 2'b00}) begin
            n_fail++;
            $display("FAIL hz1_state%0d: got pv=%b p=%0d l=%b s=%b", k, PeriodValid, PeriodOut, Locked, SpeedOut);
         end
      end
   endtask

   task automatic test_speed_change();
      for (int k = 0; k < 2; k++) begin
         pulse_gap(1000);
         n_tests++;
         if (dut_bus !== mdl_bus) begin
            n_fail++;
            $display("FAIL chg_bus%0d: got %h expected %h", k, dut_bus, mdl_bus);
         end
         n_tests++;
         if ({Locked, SpeedOut, PeriodValid, PeriodOut} !==
             {(k == 1), (k == 1) ? 2'b10 : 2'b01, 1'b1, 11'd1000}) begin
            n_fail++;
            $display("FAIL chg_state%0d: got l=%b s=%b pv=%b p=%0d", k, Locked, SpeedOut, PeriodValid, PeriodOut);
         end
      end
   endtask

   task automatic test_tolerance();
      int         gaps   [11] = '{2002, 2003, 2000, 1998, 750, 2001, 1999, 498, 503, 2002, 1998};
      logic       exp_l  [11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
      logic [1:0] exp_so [11] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
      for (int k = 0; k < 11; k++) begin
         pulse_gap(gaps[k]);
         n_tests++;
         if (dut_bus !== mdl_bus) begin
            n_fail++;
            $display("FAIL tol_bus%0d: got %h expected %h", k, dut_bus, mdl_bus);
         end
         n_tests++;
         if ({Locked, SpeedOut, PeriodValid, PeriodOut} !== {exp_l[k], exp_so[k], 1'b1, 11'(gaps[k])}) begin
            n_fail++;
            $display("FAIL tol_state%0d: got l=%b s=%b pv=%b p=%0d expected l=%b s=%b p=%0d",
                     k, Locked, SpeedOut, PeriodValid, PeriodOut, exp_l[k], exp_so[k], gaps[k]);
         end
      end
   endtask

   task automatic test_timeout();
      int rise = -1;
      for (int i = 0; i < 2100; i++) begin
         drive(1'b0);
         if ((Timeout === 1'b1) && (rise < 0)) rise = i;
         n_tests++;
         if (dut_bus !== mdl_bus) begin
            n_fail++;
            $display("FAIL tmo_bus%0d: got %h expected %h", i, dut_bus, mdl_bus);
         end
      end
      n_tests++;
      if ((rise != 2046) || ({Timeout, Locked, SpeedOut} !== 4'b1011)) begin
         n_fail++;
         $display("FAIL tmo_rise: got idx=%0d t=%b l=%b s=%b expected idx=2046 t=1 l=0 s=11",
                  rise, Timeout, Locked, SpeedOut);
      end
      drive(1'b1);
      n_tests++;
      if ({PeriodValid, Timeout, Locked} !== 3'b000) begin
         n_fail++;
         $display("FAIL tmo_repulse: got pv=%b t=%b l=%b expected 000", PeriodValid, Timeout, Locked);
      end
      pulse_gap(2000);
      n_tests++;
      if ({PeriodValid, PeriodOut, Locked, dut_bus} !== {1'b1, 11'd2000, 1'b0, mdl_bus}) begin
         n_fail++;
         $display("FAIL tmo_reref: got pv=%b p=%0d l=%b", PeriodValid, PeriodOut, Locked);
      end
   endtask

   task automatic test_reset_mid_period();
      repeat (3) drive(1'b1);
      repeat (5) drive(1'b0);
      n_tests++;
      if ({Locked, SpeedOut} !== 3'b100) begin
         n_fail++;
         $display("FAIL rstmid_prelock: got %b expected 100", {Locked, SpeedOut});
      end
      Reset = 1'b1;
      drive(1'b1);
      n_tests++;
      if (dut_bus !== 16'h0000) begin
         n_fail++;
         $display("FAIL rstmid_values: got %h expected %h", dut_bus, 16'h0000);
      end
      Reset = 1'b0;
      repeat (3) drive(1'b0);
      drive(1'b1);
      n_tests++;
      if ({PeriodValid, Locked, dut_bus} !== {1'b0, 1'b0, mdl_bus}) begin
         n_fail++;
         $display("FAIL rstmid_first: got pv=%b l=%b %h expected %h", PeriodValid, Locked, dut_bus, mdl_bus);
      end
      drive(1'b1);
      n_tests++;
      if ({PeriodValid, PeriodOut} !== {1'b1, 11'd1}) begin
         n_fail++;
         $display("FAIL rstmid_second: got pv=%b p=%0d expected 1/1", PeriodValid, PeriodOut);
      end
   endtask

   task automatic test_random();
      int g;
      int kind;
      Reset = 1'b1;
      drive(1'b0);
      Reset = 1'b0;
      for (int t = 0; t < 24; t++) begin
         kind = int'($urandom_range(0, 9));
         if (kind <= 6) begin
            g = NOM[$urandom_range(0, 3)] + int'($urandom_range(0, 8)) - 4;
            if (g < 1) g = 1;
         end else if (kind == 7) begin
            g = int'($urandom_range(1, 2046));
         end else if (kind == 8) begin
            g = 1;
         end else begin
            g = int'($urandom_range(2048, 2100));
         end
         for (int j = 0; j < g; j++) begin
            drive((j == g - 1) ? 1'b1 : 1'b0);
            n_tests++;
            if (dut_bus !== mdl_bus) begin
               n_fail++;
               $display("FAIL rnd_bus t%0d gap%0d c%0d: got %h expected %h", t, g, j, dut_bus, mdl_bus);
            end
         end
      end
   endtask

   initial begin
      Reset   = 1'b1;
      PulseIn = 1'b0;
      @(negedge ClockIn);
      test_reset();
      test_back_to_back();
      test_1hz_lock();
      test_speed_change();
      test_tolerance();
      test_timeout();
      test_reset_mid_period();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rate_detector.md
Name: rate_detector

Overview:
Receive-side counterpart to the rate-divider/enable-pulse generator. It watches a one-cycle enable pulse train and measures the number of clock cycles between pulses. It then decodes that period back into the 2-bit speed code (full, 1 Hz, 0.5 Hz, 0.25 Hz at the 500 Hz automarker clock). A lock state machine means the decoded code is trusted only after consecutive matching periods. Used for self-checking and for loop-back between boards.

Parameters:
CW, 11, interval counter / period width (max 2047)
PERIOD_FULL, 1, nominal cycles between pulses for code 00
PERIOD_1HZ, 500, nominal period for code 01
PERIOD_HALF, 1000, nominal period for code 10
PERIOD_QUARTER, 2000, nominal period for code 11
TOL, 2, accepted deviation ± cycles around each nominal period
LOCK_COUNT, 2, consecutive matching periods required to lock

Ports:
ClockIn  in  1  single system clock, all flops on posedge
Reset  in  1  synchronous, active-high reset
PulseIn  in  1  enable pulse train; each high cycle is one pulse
SpeedOut  out  2  last locked speed code
Locked  out  1  high while the pulse train matches SpeedOut
PeriodOut  out  CW  most recently measured period, in cycles
PeriodValid  out  1  one-cycle strobe when PeriodOut updates
Timeout  out  1  high after no pulse for 2^CW-1 cycles

Behaviour:
- Reset (sync, highest priority over PulseIn): SpeedOut=00, Locked=0, PeriodOut=0, PeriodValid=0, Timeout=0, IntCnt=0, state=SEARCH, MatchCnt=0.
- Interval counter IntCnt:
  - Clears to 0 on a PulseIn cycle.
  - Otherwise increments, saturating at 2^CW-1.
  - Measured period = IntCnt+1, so back-to-back pulses (PulseIn held high) give period 1.
- Classification (combinational on period):
  - A period in [P-TOL, P+TOL] of a nominal period maps to that period's code.
  - Any other period is "unmatched". Ranges must not overlap; an overlap is a parameter error and fails an elaboration check.
- FSM states SEARCH, TRACK, LOCKED:
  - SEARCH: the first PulseIn moves to TRACK with MatchCnt=0. No PeriodValid, because there is no reference edge.
  - TRACK, on each PulseIn:
    - PeriodValid=1 and PeriodOut=period on the next edge.
    - Matched code equal to Cand, or MatchCnt==0: Cand=code, MatchCnt+1.
    - Matched code different from Cand: Cand=code, MatchCnt=1.
    - Unmatched period: MatchCnt=0.
    - When MatchCnt reaches LOCK_COUNT: go to LOCKED, with SpeedOut=Cand and Locked=1 on the same edge as that PeriodValid.
  - LOCKED, on each PulseIn:
    - Same code: stay, PeriodValid strobes.
    - Different matched code: Locked=0, go to TRACK with Cand=new code and MatchCnt=1.
    - Unmatched period: Locked=0, go to TRACK with MatchCnt=0.
    - In both exits SpeedOut holds its old value until relock.
- Timeout:
  - When IntCnt saturates in TRACK or LOCKED: Timeout=1, Locked=0, go to SEARCH. The next pulse is treated as a first pulse.
  - Timeout clears on the edge after the next PulseIn, or on Reset.
  - In SEARCH, IntCnt saturating sets Timeout but causes no other change.
- Latency: every output is registered, one cycle after PulseIn is sampled. PeriodValid is never high for two consecutive cycles unless PulseIn is high in consecutive cycles.
- Speed change mid-period in the source: the stretched or shortened transitional period is classified like any other. It either relocks or breaks lock per the rules above.

Decomposition:
- Shared package: speed code constants (SPD_FULL=00, SPD_1HZ=01, SPD_HALF=10, SPD_QUARTER=11), nominal period constants (shared with the rate divider), and the FSM state encoding.
- One natural sub-module: rate_period_classifier. Purely combinational; period in, code plus match flag out.
- FSM, interval counter and MatchCnt stay in rate_detector.

Test Plan:
1. Release Reset, hold PulseIn=1 -> PeriodValid every cycle with PeriodOut=1. Locked=1 and SpeedOut=00 on the second PeriodValid.
2. Pulses every 500 cycles -> PeriodOut=500. Locked=1 and SpeedOut=01 after the third pulse. No PeriodValid on the first pulse.
3. Locked at 01, switch to 1000-cycle spacing -> first period 1000 gives Locked=0 with SpeedOut still 01. Second period 1000 gives Locked=1 and SpeedOut=10.
4. Periods 2002 then 2003 -> 2002 matches code 11; 2003 is unmatched (PeriodValid=1, PeriodOut=2003). Period 750 is unmatched, Locked=0, SpeedOut unchanged.
5. Locked at 11, stop pulses -> Timeout=1 and Locked=0 once IntCnt reaches 2047. Next pulse gives no PeriodValid. Timeout clears the following cycle.
6. Reset asserted mid-period while locked, with PulseIn=1 in the same cycle -> all outputs return to reset values on that edge, and the pulse is ignored.
